// File: rtl/demux2_buf_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer: the per-channel
// FIFO depth and the channel encoding used on in_sel.
package demux2_buf_pkg;

  // Entries held by each channel FIFO.
  localparam int FIFO_DEPTH = 2;

  // Occupancy value at which a channel FIFO reports full.
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  // Destination encoding carried on in_sel.
  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

endpackage

// File: rtl/demux2_fifo2.sv
// Two-entry registered FIFO used once per demux channel. The head word is
// read straight from storage through the read pointer, so a pushed word is
// visible one cycle after the push edge and never bypasses storage.
module demux2_fifo2 #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             valid,
  output logic             full
);
  import demux2_buf_pkg::*;

  logic [width-1:0] r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO and a pop from an empty one are ignored, so the
  // occupancy can never leave 0..2 whatever the caller drives.
  assign w_push = push & ~full;
  assign w_pop  = pop & valid;

  assign valid = (r_count != 2'd0);
  assign full  = (r_count == FULL_COUNT);
  assign dout  = r_mem[r_rd_ptr];

  // Storage: write the incoming word into the slot under the write pointer.
  // NOTE: storage is reset as well as the control state because the head
  // word is exported directly and must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Control: 1-bit pointers wrap naturally; the count moves only when
  // exactly one of push/pop happens in the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 demultiplexer. Steers each accepted upstream word into the
// FIFO of the channel named by in_sel; each channel drains independently so
// a stalled consumer only back-pressures words aimed at its own channel.
module demux2_buf #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [width-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [width-1:0] b_data
);
  import demux2_buf_pkg::*;

  channel_e w_sel;
  logic     w_a_full;
  logic     w_b_full;
  logic     w_accept;
  logic     w_push_a;
  logic     w_push_b;

  assign w_sel = channel_e'(in_sel);

  // Ready depends only on the selected FIFO's registered fullness, so there
  // is no combinational path from either consumer's ready to in_ready and a
  // full FIFO refuses even in a cycle where it is also being popped.
  assign in_ready = (w_sel == CH_B) ? ~w_b_full : ~w_a_full;
  assign w_accept = in_valid & in_ready;

  // Exactly one FIFO is written per accepted word.
  assign w_push_a = w_accept & (w_sel == CH_A);
  assign w_push_b = w_accept & (w_sel == CH_B);

  demux2_fifo2 #(.width(width)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_a),
    .din   (in_data),
    .pop   (a_ready),
    .dout  (a_data),
    .valid (a_valid),
    .full  (w_a_full)
  );

  demux2_fifo2 #(.width(width)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_b),
    .din   (in_data),
    .pop   (b_ready),
    .dout  (b_data),
    .valid (b_valid),
    .full  (w_b_full)
  );

endmodule

// File: tb/tb_demux2_buf.sv
// Self-checking bench for demux2_buf: directed vector table for the
// single-cycle and full/empty corners, a hand-written reset-mid-burst
// sequence, and a randomized run checked against a queue-based model.
module tb_demux2_buf;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;

  int n_tests;
  int n_fail;

  demux2_buf #(.width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed vector: inputs for a cycle, in_ready expected before the
  // edge, and channel outputs expected after it (data checked only if valid).
  typedef struct {
    logic         v;
    logic         sel;
    logic [W-1:0] d;
    logic         ar;
    logic         br;
    logic         rdy;
    logic         av;
    logic [W-1:0] ad;
    logic         bv;
    logic [W-1:0] bd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic sel, input logic [W-1:0] d,
                     input logic ar, input logic br, input logic rdy,
                     input logic av, input logic [W-1:0] ad,
                     input logic bv, input logic [W-1:0] bd);
    vec_t e;
    e.v = v; e.sel = sel; e.d = d; e.ar = ar; e.br = br; e.rdy = rdy;
    e.av = av; e.ad = ad; e.bv = bv; e.bd = bd;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic ar, input logic br);
    in_valid = v; in_sel = sel; in_data = d; a_ready = ar; b_ready = br;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " a_valid"},  32'(a_valid), 32'd0);
    check({tag, " b_valid"},  32'(b_valid), 32'd0);
    check({tag, " a_data"},   32'(a_data),  32'd0);
    check({tag, " b_data"},   32'(b_data),  32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // ---- Reset then idle ----
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle");

    // ---- Directed vectors ----
    // Both channels, consumers ready: each word valid one cycle after accept.
    add(1, 0, 4'h3, 1, 1, 1,  1, 4'h3, 0, 4'h0);
    add(1, 1, 4'h5, 1, 1, 1,  0, 4'h0, 1, 4'h5);
    add(0, 1, 4'h0, 1, 1, 1,  0, 4'h0, 0, 4'h0);
    // A stalled: two accepts fill it, third is refused, B still accepts.
    add(1, 0, 4'h1, 0, 1, 1,  1, 4'h1, 0, 4'h0);
    add(1, 0, 4'h2, 0, 1, 1,  1, 4'h1, 0, 4'h0);
    add(1, 0, 4'h3, 0, 1, 0,  1, 4'h1, 0, 4'h0);
    add(1, 1, 4'h9, 0, 0, 1,  1, 4'h1, 1, 4'h9);
    // A full and popping in the same cycle: still no accept (no bypass).
    add(1, 0, 4'h3, 1, 0, 0,  1, 4'h2, 1, 4'h9);
    // Next cycle the held word is accepted.
    add(1, 0, 4'h3, 0, 0, 1,  1, 4'h2, 1, 4'h9);
    add(0, 0, 4'h0, 1, 1, 0,  1, 4'h3, 0, 4'h0);
    add(0, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 4'h0);
    // Count held at 1 by push+pop on A, across pointer wrap.
    add(1, 0, 4'hA, 0, 0, 1,  1, 4'hA, 0, 4'h0);
    add(1, 0, 4'hB, 1, 0, 1,  1, 4'hB, 0, 4'h0);
    add(1, 0, 4'hC, 1, 0, 1,  1, 4'hC, 0, 4'h0);
    add(0, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      step();
      check($sformatf("vec%0d a_valid", i), 32'(a_valid), 32'(tbl[i].av));
      check($sformatf("vec%0d b_valid", i), 32'(b_valid), 32'(tbl[i].bv));
      if (tbl[i].av) check($sformatf("vec%0d a_data", i), 32'(a_data), 32'(tbl[i].ad));
      if (tbl[i].bv) check($sformatf("vec%0d b_data", i), 32'(b_data), 32'(tbl[i].bd));
    end

    // ---- Reset asserted mid-burst discards buffered words ----
    drive(1, 0, 4'h6, 0, 0); step();
    drive(1, 0, 4'h7, 0, 0); step();
    drive(1, 1, 4'hE, 0, 0); step();
    check("burst a_valid", 32'(a_valid), 32'd1);
    check("burst b_data",  32'(b_data),  32'hE);
    drive(0, 0, '0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    step();
    check_idle("midrst+1");
    rst = 1'b0;
    step();
    check_idle("postrst");

    // ---- Randomized alternating traffic vs queue model ----
    begin
      int sent;
      int cyc;
      logic exp_rdy;
      logic acc;
      logic pop_a;
      logic pop_b;
      sent = 0;
      cyc  = 0;
      while ((sent < 16 || qa.size() != 0 || qb.size() != 0) && cyc < 400) begin
        drive(sent < 16, 1'(sent), W'($urandom), 1'($urandom), 1'($urandom));
        #1;
        exp_rdy = in_sel ? (qb.size() < 2) : (qa.size() < 2);
        check("rand in_ready", 32'(in_ready), 32'(exp_rdy));
        check("rand a_valid", 32'(a_valid), 32'(qa.size() != 0));
        check("rand b_valid", 32'(b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) check("rand a_data", 32'(a_data), 32'(qa[0]));
        if (qb.size() != 0) check("rand b_data", 32'(b_data), 32'(qb[0]));
        acc   = in_valid && exp_rdy;
        pop_a = a_ready && (qa.size() != 0);
        pop_b = b_ready && (qb.size() != 0);
        step();
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
        if (acc) begin
          if (in_sel) qb.push_back(in_data);
          else        qa.push_back(in_data);
          sent++;
        end
        cyc++;
      end
      check("rand drained in budget", 32'(cyc < 400), 32'd1);
      drive(0, 0, '0, 0, 0);
      #1;
      check("rand end a_valid", 32'(a_valid), 32'd0);
      check("rand end b_valid", 32'(b_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
